// File: rtl/risc_pack.sv
// Shared Qrisc32 types and constants for the memory arbiter.
package risc_pack;

    typedef enum logic [1:0] {ARB_IDLE, ARB_GNT_I, ARB_GNT_D} arb_state_t;

    parameter logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

    localparam logic [15:0] ARB_WDOG_MAX = 16'hFFFF;

    // Winner selection from IDLE; rr_en picks round-robin over dmem-first priority.
    function automatic arb_state_t arb_pick(input logic req_i, input logic req_d,
                                            input logic last_d, input logic rr_en);
        arb_state_t pick;
        if (req_i && req_d) begin
            if (rr_en) begin
                pick = last_d ? ARB_GNT_I : ARB_GNT_D;
            end else begin
                pick = ARB_GNT_D;
            end
        end else if (req_d) begin
            pick = ARB_GNT_D;
        end else if (req_i) begin
            pick = ARB_GNT_I;
        end else begin
            pick = ARB_IDLE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/avalon_port.sv
// Minimal Avalon-style port bundle shared by the pipeline requesters and the bus.
interface avalon_port;
    logic [31:0] address_r;
    logic [31:0] data_w;
    logic [31:0] data_r;
    logic        rd;
    logic        wr;
    logic        wait_req;

    modport master (output address_r, output data_w, output rd, output wr,
                    input data_r, input wait_req);
    modport slave  (input address_r, input data_w, input rd, input wr,
                    output data_r, output wait_req);
endinterface

// File: rtl/qrisc32_arb_wdog.sv
// Stall watchdog for the memory arbiter: counts granted wait cycles and flags the
// cycle in which the running count (including the current cycle) reaches TIMEOUT_CYCLES.
module qrisc32_arb_wdog
    import risc_pack::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic        WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam int unsigned LIMIT_I = (TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1);
    localparam logic [15:0] LIMIT   = LIMIT_I[15:0];

    logic [15:0] cnt_r;

    // Wait-cycle counter: cleared outside a grant, saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 16'd0;
        end else if (clr) begin
            cnt_r <= 16'd0;
        end else if (en && (cnt_r != ARB_WDOG_MAX)) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Expiry compares the count before this cycle's increment against T-1.
    always_comb begin
        if (WD_EN && en && (cnt_r == LIMIT)) begin
            expired = 1'b1;
        end else begin
            expired = 1'b0;
        end
    end

endmodule

// File: rtl/qrisc32_mem_arbiter.sv
// Two-port Avalon arbiter sharing one bus between instruction fetch and the MEM stage.
// Build option QRISC_ARB_RR_EN selects round-robin; otherwise dmem has fixed priority.
module qrisc32_mem_arbiter
    import risc_pack::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        areset,
    avalon_port.slave   ifetch,
    avalon_port.slave   dmem,
    avalon_port.master  bus,
    output logic        bus_err,
    output logic        err_src
);

`ifdef QRISC_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    arb_state_t  state_r;
    arb_state_t  state_nxt_s;
    logic        last_d_r;
    logic        last_d_nxt_s;
    logic        err_src_r;
    logic        err_src_nxt_s;

    logic        req_i_s;
    logic        req_d_s;
    logic        granted_s;
    logic        gnt_d_s;
    logic        req_g_s;
    logic        done_s;
    logic        abort_s;
    logic        expired_s;

    logic [31:0] bus_addr_s;
    logic [31:0] bus_wdata_s;
    logic        bus_rd_s;
    logic        bus_wr_s;
    logic        i_wait_s;
    logic [31:0] i_data_s;
    logic        d_wait_s;
    logic [31:0] d_data_s;
    logic        bus_err_s;
    logic        err_src_s;
    logic        unused_ifetch_data_s;

    assign unused_ifetch_data_s = ^ifetch.data_w;

    assign req_i_s   = ifetch.rd | ifetch.wr;
    assign req_d_s   = dmem.rd | dmem.wr;
    assign granted_s = (state_r != ARB_IDLE);
    assign gnt_d_s   = (state_r == ARB_GNT_D);
    assign req_g_s   = gnt_d_s ? req_d_s : req_i_s;

    // A dropped request is a protocol violation, so it outranks both completion and abort.
    assign done_s    = granted_s & req_g_s & ~bus.wait_req;
    assign abort_s   = granted_s & req_g_s & bus.wait_req & expired_s;

    qrisc32_arb_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (areset),
        .clr     (~granted_s),
        .en      (granted_s & bus.wait_req),
        .expired (expired_s)
    );

    // State, round-robin pointer and abort-source registers.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_r   <= ARB_IDLE;
            last_d_r  <= 1'b1;
            err_src_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            last_d_r  <= last_d_nxt_s;
            err_src_r <= err_src_nxt_s;
        end
    end

    // Next-state logic: pick in IDLE, return to IDLE on drop, completion or abort.
    always_comb begin
        state_nxt_s   = state_r;
        last_d_nxt_s  = last_d_r;
        err_src_nxt_s = err_src_r;
        case (state_r)
            ARB_IDLE: begin
                state_nxt_s = arb_pick(req_i_s, req_d_s, last_d_r, RR_EN);
            end
            ARB_GNT_I, ARB_GNT_D: begin
                if (!req_g_s) begin
                    state_nxt_s = ARB_IDLE;
                end else if (done_s) begin
                    state_nxt_s  = ARB_IDLE;
                    last_d_nxt_s = gnt_d_s;
                end else if (abort_s) begin
                    state_nxt_s   = ARB_IDLE;
                    err_src_nxt_s = gnt_d_s;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // Bus and requester muxing; rd together with wr is issued as a write.
    always_comb begin
        bus_addr_s  = 32'h0000_0000;
        bus_wdata_s = 32'h0000_0000;
        bus_rd_s    = 1'b0;
        bus_wr_s    = 1'b0;
        i_wait_s    = 1'b1;
        i_data_s    = 32'h0000_0000;
        d_wait_s    = 1'b1;
        d_data_s    = 32'h0000_0000;
        bus_err_s   = 1'b0;
        err_src_s   = err_src_r;
        case (state_r)
            ARB_IDLE: begin
                bus_rd_s = 1'b0;
            end
            ARB_GNT_I: begin
                bus_addr_s = ifetch.address_r;
                if (abort_s) begin
                    i_wait_s  = 1'b0;
                    i_data_s  = ARB_ERR_DATA;
                    bus_err_s = 1'b1;
                    err_src_s = 1'b0;
                end else begin
                    bus_rd_s = ifetch.rd & ~ifetch.wr;
                    bus_wr_s = ifetch.wr;
                    i_wait_s = bus.wait_req;
                    i_data_s = bus.data_r;
                end
            end
            ARB_GNT_D: begin
                bus_addr_s  = dmem.address_r;
                bus_wdata_s = dmem.data_w;
                if (abort_s) begin
                    d_wait_s  = 1'b0;
                    d_data_s  = ARB_ERR_DATA;
                    bus_err_s = 1'b1;
                    err_src_s = 1'b1;
                end else begin
                    bus_rd_s = dmem.rd & ~dmem.wr;
                    bus_wr_s = dmem.wr;
                    d_wait_s = bus.wait_req;
                    d_data_s = bus.data_r;
                end
            end
            default: begin
                bus_rd_s = 1'b0;
            end
        endcase
    end

    assign bus.address_r   = bus_addr_s;
    assign bus.data_w      = bus_wdata_s;
    assign bus.rd          = bus_rd_s;
    assign bus.wr          = bus_wr_s;
    assign ifetch.wait_req = i_wait_s;
    assign ifetch.data_r   = i_data_s;
    assign dmem.wait_req   = d_wait_s;
    assign dmem.data_r     = d_data_s;
    assign bus_err         = bus_err_s;
    assign err_src         = err_src_s;

endmodule

// File: doc/qrisc32_mem_arbiter.md
# qrisc32_mem_arbiter

Two-port Avalon memory arbiter for the Qrisc32 core. It shares one external `avalon_port` bus between the instruction-fetch stage and the MEM stage (LDR/STR data accesses). It grants one requester at a time, holds the grant for the whole wait-request handshake, and aborts stalled transfers with a watchdog. It sits between the pipeline and the single memory/bus slave.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum granted cycles with `bus.wait_req`=1 before abort. 0 disables the watchdog. Legal range is 0..65535.

Ports:
- `clk`  in  1  core clock; all state changes on its rising edge.
- `areset`  in  1  asynchronous, active-low reset.
- `ifetch`  interface  avalon_port  instruction requester.
  - Arbiter reads `address_r`, `rd`, `wr`.
  - Arbiter drives `data_r`, `wait_req`.
- `dmem`  interface  avalon_port  data requester.
  - Arbiter reads `address_r`, `data_w`, `rd`, `wr`.
  - Arbiter drives `data_r`, `wait_req`.
- `bus`  interface  avalon_port  shared master side.
  - Arbiter drives `address_r`, `data_w`, `rd`, `wr`.
  - Arbiter reads `data_r`, `wait_req`.
- `bus_err`  out  1  one-cycle pulse on watchdog abort.
- `err_src`  out  1  requester of the last abort: 0 = ifetch, 1 = dmem. Holds its value until the next abort.

## Operation
- State machine `ARB_IDLE`, `ARB_GNT_I`, `ARB_GNT_D`. The state register is the only timing state besides the watchdog counter and the round-robin pointer `last_d`.
- A requester is requesting when `rd|wr` is 1. Having `rd` and `wr` both at 1 is treated as a write.
- `ARB_IDLE`:
  - `bus.rd`=`bus.wr`=0; `bus.address_r`/`bus.data_w` are 0.
  - Both requesters see `wait_req`=1.
  - The winner is chosen from the current requests. The next state is `ARB_GNT_I` or `ARB_GNT_D`; with no request, stay in IDLE.
- `ARB_GNT_x`:
  - The granted requester's `address_r`/`data_w`/`rd`/`wr` pass combinationally to `bus`.
  - `bus.data_r` and `bus.wait_req` pass back to the granted requester only.
  - The other requester sees `wait_req`=1 and `data_r`=0.
- Completion: the first granted cycle with `bus.wait_req`=0. Read data is valid in that cycle. Next state is ARB_IDLE, and `last_d` is updated to the granted side.
- Protocol violation: if the granted requester drops `rd|wr` before completion, the arbiter returns to ARB_IDLE next cycle. No error is reported.
- Watchdog abort:
  - A counter clears on grant and increments each granted cycle with `bus.wait_req`=1.
  - When the count equals `TIMEOUT_CYCLES`, the abort happens in that cycle:
    - `bus.rd`/`bus.wr` are forced to 0.
    - The granted requester sees `wait_req`=0 and `data_r`=`ARB_ERR_DATA`.
    - `bus_err`=1 and `err_src` is updated.
  - Next state is ARB_IDLE.
- Arbitration policy: see Configuration.

## Timing
- Reset values:
  - State ARB_IDLE, `last_d`=1 so ifetch wins first, counter 0.
  - `bus.rd`=`bus.wr`=0, `bus.address_r`=`bus.data_w`=0.
  - `ifetch.wait_req`=`dmem.wait_req`=1.
  - `bus_err`=0, `err_src`=0.
- Reset asserted mid-transfer drops `bus.rd`/`bus.wr` immediately (asynchronously).
- Latency:
  - Request seen in IDLE at cycle N → bus strobe at N+1.
  - With a zero-wait slave, completion is at N+1 and IDLE at N+2, so the minimum cost is 2 cycles per transfer.
  - A requester holding `rd` back-to-back is regranted every 2 cycles.
- Abort timing: with `TIMEOUT_CYCLES`=T, the abort occurs in granted cycle T (counting from 1) if `bus.wait_req` stays 1 throughout.
- Simultaneous completion and timeout in the same cycle: completion wins, with no `bus_err`.

## Configuration
- Macro `QRISC_ARB_RR_EN`:
  - Defined: round-robin. On simultaneous requests in IDLE, the side not granted last wins (`last_d`=1 → ifetch, else dmem).
  - Undefined: fixed priority, dmem always beats ifetch, so a stalled MEM stage never waits on fetch. `last_d` is still kept but ignored.
- A single requester is always granted regardless of the macro.

## Structure
- Add to `risc_pack`:
  - `typedef enum logic[1:0] {ARB_IDLE, ARB_GNT_I, ARB_GNT_D} arb_state_t`.
  - `parameter[31:0] ARB_ERR_DATA = 32'hDEAD_BEEF`.
- Sub-module `qrisc32_arb_wdog` holds the 16-bit watchdog counter with clear/enable inputs and a `expired` output. It outputs constant 0 when `TIMEOUT_CYCLES`=0.
- Arbitration and muxing stay in `qrisc32_mem_arbiter`.

## Test plan
- After reset, ifetch reads 0x100 against a zero-wait slave returning 0x12345678:
  - Bus `rd` and `address_r`=0x100 appear one cycle after the request.
  - `ifetch.data_r`=0x12345678 with `wait_req`=0 in the same cycle; IDLE follows.
- dmem writes 0x55AA to 0x200 while the slave holds `wait_req`=1 for 3 cycles:
  - `bus.wr`, `address_r` and `data_w` stay stable for 4 granted cycles.
  - `dmem.wait_req` mirrors `bus.wait_req`.
- Both requesters assert continuously:
  - Without `QRISC_ARB_RR_EN`: dmem gets every grant.
  - With it: grants alternate I, D, I, D, starting with I after reset.
- `TIMEOUT_CYCLES`=4, slave never deasserts `wait_req`:
  - `bus_err` pulses in granted cycle 4 with `err_src` matching the requester.
  - Requester sees `data_r`=0xDEADBEEF and `wait_req`=0; bus strobes drop.
- `areset` pulled low during a stalled dmem read:
  - `bus.rd`=0 and both `wait_req`=1 immediately.
  - After release, the arbiter is in IDLE and grants ifetch first on simultaneous requests.
- Granted ifetch drops `rd` before completion: IDLE next cycle, no `bus_err`, and a pending dmem request is granted the cycle after.
